cdctl_pll_ctrl: RTL and testbench

PLL supervisor for the iCE40 PLL that derives the 40 MHz core clock from the 16 MHz reference. It runs on the reference clock and drives the PLL's active-low reset. It synchronises and filters the PLL lock output, retries on lock timeout and restarts the PLL when lock is lost. Downstream logic gets a clean `pll_ready` level, a sticky failure flag and a lock-loss counter.

---
 rtl/cdctl_pll_ctrl_if.sv | 19 +
 rtl/cdctl_pll_ctrl.sv | 133 +++++++++++++
 tb/tb_cdctl_pll_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdctl_pll_ctrl_if.sv
`timescale 1ns/1ps
// cdctl_pll_ctrl_if: control/status bundle between the PLL supervisor and its surroundings
interface cdctl_pll_ctrl_if;
    logic       restart;
    logic       pll_lock;
    logic       pll_resetb;
    logic       pll_ready;
    logic       pll_fail;
    logic [7:0] lost_cnt;
    logic [2:0] state;
    modport master (
        input  restart, pll_lock,
        output pll_resetb, pll_ready, pll_fail, lost_cnt, state
    );
    modport slave (
        output restart, pll_lock,
        input  pll_resetb, pll_ready, pll_fail, lost_cnt, state
    );
endinterface

// File: rtl/cdctl_pll_ctrl.sv
`timescale 1ns/1ps
// cdctl_pll_ctrl: drives the PLL reset, qualifies its lock, retries on timeout and recovers from lock loss
module cdctl_pll_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 16000,
    parameter int LOCK_FILTER  = 256,
    parameter int MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    cdctl_pll_ctrl_if.master bus
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int YW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t        cur, nxt;
    logic          lock_m, lock_s;
    logic [RW-1:0] rst_cnt;
    logic [15:0]   tmo_cnt;
    logic [FW-1:0] flt_cnt;
    logic [YW-1:0] retry, retry_d, retry_inc;
    logic [7:0]    lost_cnt;
    logic          lost_inc, rst_done, tmo_hit, flt_done, retry_max;
    logic          resetb_q, ready_q, fail_q;
    logic          resetb_d, ready_d, fail_d;

    assign rst_done  = rst_cnt == RW'(RST_CYCLES - 1);
    assign tmo_hit   = tmo_cnt == 16'(LOCK_TIMEOUT - 1);
    assign flt_done  = flt_cnt == FW'(LOCK_FILTER - 1);
    assign retry_inc = retry + 1'b1;
    assign retry_max = retry_inc == YW'(MAX_RETRY);

    assign bus.pll_resetb = resetb_q;
    assign bus.pll_ready  = ready_q;
    assign bus.pll_fail   = fail_q;
    assign bus.lost_cnt   = lost_cnt;
    assign bus.state      = cur;

    // two-flop synchroniser: the only place the asynchronous lock is sampled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= bus.pll_lock;
            lock_s <= lock_m;
        end
    end

    // sequencing decisions; restart overrides everything but still lets a RUN lock loss be counted
    always_comb begin
        nxt      = cur;
        retry_d  = retry;
        lost_inc = 1'b0;
        case (cur)
            RESET: nxt = rst_done ? WAIT_LOCK : RESET;
            WAIT_LOCK: begin
                if (lock_s) nxt = STABLE;
                else if (tmo_hit) begin
                    nxt     = retry_max ? FAIL : RESET;
                    retry_d = retry_inc;
                end
            end
            STABLE: begin
                if (!lock_s) nxt = WAIT_LOCK;
                else if (flt_done) begin
                    nxt     = RUN;
                    retry_d = '0;
                end else if (tmo_hit) begin
                    nxt     = retry_max ? FAIL : RESET;
                    retry_d = retry_inc;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    nxt      = RESET;
                    retry_d  = '0;
                    lost_inc = 1'b1;
                end
            end
            FAIL: nxt = FAIL;
            default: nxt = RESET;
        endcase
        if (bus.restart) begin
            nxt     = RESET;
            retry_d = '0;
        end
        resetb_d = nxt inside {WAIT_LOCK, STABLE, RUN};
        ready_d  = nxt == RUN;
        fail_d   = nxt == FAIL;
    end

    // state register and output flops, so every output switches on the same edge as the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= RESET;
            resetb_q <= 1'b0;
            ready_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            cur      <= nxt;
            resetb_q <= resetb_d;
            ready_q  <= ready_d;
            fail_q   <= fail_d;
        end
    end

    // counters; tmo_cnt only restarts from RESET so a glitching lock cannot dodge the timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt  <= '0;
            tmo_cnt  <= '0;
            flt_cnt  <= '0;
            retry    <= '0;
            lost_cnt <= '0;
        end else begin
            rst_cnt  <= (cur == RESET && nxt == RESET && !bus.restart) ? rst_cnt + 1'b1 : '0;
            tmo_cnt  <= (cur == WAIT_LOCK || cur == STABLE) ? tmo_cnt + 16'd1 : '0;
            flt_cnt  <= (cur == STABLE && nxt == STABLE) ? flt_cnt + 1'b1 : '0;
            retry    <= retry_d;
            lost_cnt <= (lost_inc && lost_cnt != 8'hff) ? lost_cnt + 8'd1 : lost_cnt;
        end
    end
endmodule

// File: tb/tb_cdctl_pll_ctrl.sv
`timescale 1ns/1ps
// tb_cdctl_pll_ctrl: directed stimulus with a queue of expected output changes checked by a monitor
module tb_cdctl_pll_ctrl;
    localparam logic [2:0] RS = 3'd0, WL = 3'd1, ST = 3'd2, RN = 3'd3, FL = 3'd4;

    typedef struct packed {
        logic [31:0] c;
        logic [2:0]  s;
        logic [7:0]  l;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    ev_t         q[$];
    logic [13:0] prev = '0;
    logic        last_rn = 1'b1;

    cdctl_pll_ctrl_if bus ();

    cdctl_pll_ctrl #(
        .RST_CYCLES(4),
        .LOCK_TIMEOUT(32),
        .LOCK_FILTER(8),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // cycle index since reset release: value k means "after edge k"
    always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

    function automatic logic [13:0] tup(input logic [2:0] s, input logic [7:0] l);
        return {s, s == WL || s == ST || s == RN, s == RN, s == FL, l};
    endfunction

    function automatic void ex(input int c, input logic [2:0] s, input logic [7:0] l);
        ev_t e;
        e.c = 32'(c);
        e.s = s;
        e.l = l;
        q.push_back(e);
    endfunction

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        bus.pll_lock = 1'b0;
        bus.restart = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // drop lock in RUN, then reacquire once the PLL reset has been released
    task automatic lose(input logic [7:0] l);
        int c;
        c = cyc;
        bus.pll_lock = 1'b0;
        ex(c + 3, RS, l);
        ex(c + 7, WL, l);
        ex(c + 10, ST, l);
        ex(c + 18, RN, l);
        wait_to(c + 7);
        bus.pll_lock = 1'b1;
        wait_to(c + 20);
    endtask

    // monitor: checks reset values right after reset assertion, and every output change against the queue
    always @(negedge clk or negedge reset_n) begin
        logic [13:0] s;
        ev_t e;
        if (!reset_n && last_rn) begin
            #1;
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL pending_events got %0d required 0", q.size());
            end
            q.delete();
            s = {bus.state, bus.pll_resetb, bus.pll_ready, bus.pll_fail, bus.lost_cnt};
            checks++;
            if (s !== tup(RS, 8'd0)) begin
                errors++;
                $display("FAIL async_reset got %h required %h", s, tup(RS, 8'd0));
            end
            prev = tup(RS, 8'd0);
        end else begin
            s = {bus.state, bus.pll_resetb, bus.pll_ready, bus.pll_fail, bus.lost_cnt};
            if (s !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change got %h at cycle %0d required no change", s, cyc);
                end else begin
                    e = q.pop_front();
                    if (s !== tup(e.s, e.l) || cyc != int'(e.c)) begin
                        errors++;
                        $display("FAIL event got %h at cycle %0d required %h at cycle %0d",
                                 s, cyc, tup(e.s, e.l), e.c);
                    end
                end
                prev = s;
            end
        end
        last_rn = reset_n;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.restart = 1'b0;
        bus.pll_lock = 1'b0;

        // nominal acquisition, then three lock losses with reacquisition
        do_reset();
        ex(4, WL, 0);
        wait_to(14);
        bus.pll_lock = 1'b1;
        ex(17, ST, 0);
        ex(25, RN, 0);
        wait_to(30);
        for (int i = 1; i <= 3; i++) lose(8'(i));

        // no lock: two timeouts then FAIL; restart, then restart held in RESET
        do_reset();
        ex(4, WL, 0);
        ex(36, RS, 0);
        ex(40, WL, 0);
        ex(72, FL, 0);
        wait_to(80);
        bus.restart = 1'b1;
        ex(81, RS, 0);
        wait_to(81);
        bus.restart = 1'b0;
        ex(85, WL, 0);
        ex(117, RS, 0);
        wait_to(118);
        bus.restart = 1'b1;
        wait_to(128);
        bus.restart = 1'b0;
        ex(132, WL, 0);
        wait_to(134);

        // single glitch restarts the filter
        do_reset();
        ex(4, WL, 0);
        wait_to(4);
        bus.pll_lock = 1'b1;
        ex(7, ST, 0);
        wait_to(9);
        bus.pll_lock = 1'b0;
        ex(12, WL, 0);
        wait_to(10);
        bus.pll_lock = 1'b1;
        ex(13, ST, 0);
        ex(21, RN, 0);
        wait_to(23);

        // repeated glitches run into the timeout while in STABLE, retry then succeeds
        do_reset();
        ex(4, WL, 0);
        wait_to(4);
        bus.pll_lock = 1'b1;
        ex(7, ST, 0);
        for (int g = 9; g <= 27; g += 6) begin
            wait_to(g);
            bus.pll_lock = 1'b0;
            ex(g + 3, WL, 0);
            wait_to(g + 1);
            bus.pll_lock = 1'b1;
            ex(g + 4, ST, 0);
        end
        ex(36, RS, 0);
        ex(40, WL, 0);
        ex(41, ST, 0);
        ex(49, RN, 0);
        wait_to(51);

        // lock arriving on the timeout cycle wins
        do_reset();
        ex(4, WL, 0);
        wait_to(33);
        bus.pll_lock = 1'b1;
        ex(36, ST, 0);
        ex(44, RN, 0);
        wait_to(46);

        // restart coinciding with lock loss, then saturate lost_cnt
        do_reset();
        ex(4, WL, 0);
        wait_to(4);
        bus.pll_lock = 1'b1;
        ex(7, ST, 0);
        ex(15, RN, 0);
        wait_to(17);
        bus.pll_lock = 1'b0;
        ex(20, RS, 1);
        wait_to(19);
        bus.restart = 1'b1;
        wait_to(20);
        bus.restart = 1'b0;
        ex(24, WL, 1);
        wait_to(24);
        bus.pll_lock = 1'b1;
        ex(27, ST, 1);
        ex(35, RN, 1);
        wait_to(37);
        for (int n = 2; n <= 257; n++) lose(8'(n > 255 ? 255 : n));

        // asynchronous reset while in RUN with lost_cnt saturated
        do_reset();
        ex(4, WL, 0);
        wait_to(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
